if_id_hazard_ctrl: RTL

- IF/ID pipeline register plus ID-stage control for the 16-bit MIPS core.
- Latches the fetch stage's instruction and next-PC each cycle.
- Resolves BEQ/BNE/J in ID and drives the fetch stage's PC-select inputs (pcj_mux, choice_mux).
- Detects load-use and branch-operand hazards and drives the fetch stage's stall input for 1 or 2 cycles.

---
 rtl/if_id_hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID pipeline register with ID-stage branch/jump resolution and
// load-use / branch-operand hazard stalling for the 16-bit MIPS core.
module if_id_hazard_ctrl #(
  parameter int                 DATA_W = 16,
  parameter logic [DATA_W-1:0]  NOP    = 16'h0000,
  parameter logic [3:0]         BEQ_OP = 4'h8,
  parameter logic [3:0]         BNE_OP = 4'h9,
  parameter logic [3:0]         J_OP   = 4'hC
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] pc_calc,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [2:0]        ex_dest,
  output logic [DATA_W-1:0] id_inst,
  output logic [DATA_W-1:0] id_pc_next,
  output logic              id_valid,
  output logic [DATA_W-1:0] pcj_mux,
  output logic              choice_mux,
  output logic              stall,
  output logic              id_bubble
);

  // Branch target: PC-relative with a sign-extended 6-bit offset; wraps mod 2^DATA_W.
  function automatic logic [DATA_W-1:0] br_target(input logic [DATA_W-1:0] pc,
                                                   input logic [5:0]        imm);
    logic signed [DATA_W-1:0] off;
    off = {{(DATA_W-6){imm[5]}}, imm};
    return pc + off;
  endfunction

  logic [3:0]        op;
  logic [2:0]        rs;
  logic [2:0]        rt;
  logic [5:0]        imm6;
  logic [11:0]       imm12;
  logic              is_br;
  logic              dep;
  logic              load_use;
  logic              br_dep;
  logic              hz;
  logic [1:0]        stall_cnt;
  logic [1:0]        stall_cnt_nxt;

  assign op    = id_inst[15:12];
  assign rs    = id_inst[11:9];
  assign rt    = id_inst[8:6];
  assign imm6  = id_inst[5:0];
  assign imm12 = id_inst[11:0];
  assign is_br = (op == BEQ_OP) || (op == BNE_OP);

  // Register 0 is hardwired, so an EX write to it never creates a dependence.
  assign dep      = (ex_dest != 3'd0) && ((ex_dest == rs) || (ex_dest == rt));
  assign load_use = id_valid & ex_mem_read & dep;
  assign br_dep   = id_valid & is_br & ex_reg_write & dep;
  assign hz       = load_use | br_dep;

  assign stall     = (stall_cnt != 2'd0) | hz;
  assign id_bubble = stall;

  // Resolve branches/jumps in ID; a stall suppresses any redirect this cycle.
  always_comb begin
    choice_mux = 1'b0;
    pcj_mux    = '0;
    if (id_valid && !stall) begin
      if (op == BEQ_OP) begin
        if (rs_data == rt_data) begin
          choice_mux = 1'b1;
          pcj_mux    = br_target(id_pc_next, imm6);
        end
      end else if (op == BNE_OP) begin
        if (rs_data != rt_data) begin
          choice_mux = 1'b1;
          pcj_mux    = br_target(id_pc_next, imm6);
        end
      end else if (op == J_OP) begin
        choice_mux = 1'b1;
        pcj_mux    = {id_pc_next[DATA_W-1:12], imm12};
      end
    end
  end

  // A load feeding a branch owes one extra stall cycle beyond the detected hazard.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (stall_cnt != 2'd0) begin
      stall_cnt_nxt = stall_cnt - 2'd1;
    end else if (hz && is_br && ex_mem_read) begin
      stall_cnt_nxt = 2'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 2'd0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // IF/ID register: hold on stall, squash the wrong-path fetch on redirect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_inst    <= NOP;
      id_pc_next <= '0;
      id_valid   <= 1'b0;
    end else if (!stall) begin
      id_pc_next <= pc_calc;
      if (choice_mux) begin
        id_inst  <= NOP;
        id_valid <= 1'b0;
      end else begin
        id_inst  <= inst;
        id_valid <= 1'b1;
      end
    end
  end

endmodule
